// File: rtl/vram_write_arb.sv
// Single write-port master for the video RAM: CPU writes pass straight through,
// and a fill engine streams a latched byte/colour pair over the bitmap when the CPU is quiet.
module vram_write_arb #(
   parameter logic [15:0] BASE_ADDR = 16'h9000,
   parameter logic [15:0] FILL_LEN  = 16'h3000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   input  logic [7:0]  cpu_color,
   input  logic        cpu_we,
   input  logic        fill_req,
   input  logic [7:0]  fill_data,
   input  logic [7:0]  fill_color,
   output logic        busy,
   output logic        fill_done,
   output logic [15:0] addr,
   output logic [7:0]  din,
   output logic [7:0]  color,
   output logic        we
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [7:0]  r_fill_data;
   logic [7:0]  r_fill_color;
   logic [15:0] r_addr;
   logic [7:0]  r_din;
   logic [7:0]  r_color;
   logic        r_we;
   logic        r_busy;
   logic        r_fill_done;

   logic [15:0] w_fill_addr;
   logic        w_last;
   logic        w_empty;

   assign w_fill_addr = BASE_ADDR + r_cnt;
   assign w_last      = (r_cnt == FILL_LEN - 16'd1);
   assign w_empty     = (FILL_LEN == 16'd0);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 16'd0;
         r_fill_data  <= 8'd0;
         r_fill_color <= 8'd0;
         r_addr       <= 16'd0;
         r_din        <= 8'd0;
         r_color      <= 8'd0;
         r_we         <= 1'b0;
         r_busy       <= 1'b0;
         r_fill_done  <= 1'b0;
      end else begin
         r_we        <= 1'b0;
         r_fill_done <= 1'b0;
         // CPU always owns the bus in its cycle; the fill simply skips that slot
         if (cpu_we) begin
            r_we    <= 1'b1;
            r_addr  <= cpu_addr;
            r_din   <= cpu_din;
            r_color <= cpu_color;
         end
         unique case (r_state)
            S_IDLE: begin
               if (fill_req) begin
                  r_fill_data  <= fill_data;
                  r_fill_color <= fill_color;
                  r_cnt        <= 16'd0;
                  r_busy       <= 1'b1;
                  r_state      <= S_FILL;
               end
            end
            S_FILL: begin
               if (fill_req) begin
                  r_fill_data  <= fill_data;
                  r_fill_color <= fill_color;
                  r_cnt        <= 16'd0;
               end else if (w_empty) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_fill_done <= 1'b1;
               end else if (!cpu_we) begin
                  r_we    <= 1'b1;
                  r_addr  <= w_fill_addr;
                  r_din   <= r_fill_data;
                  r_color <= r_fill_color;
                  if (w_last) begin
                     r_state     <= S_IDLE;
                     r_busy      <= 1'b0;
                     r_fill_done <= 1'b1;
                     r_cnt       <= 16'd0;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign fill_done = r_fill_done;
   assign addr      = r_addr;
   assign din       = r_din;
   assign color     = r_color;
   assign we        = r_we;

endmodule
